// File: rtl/cpu_pkg.sv
// Shared widths, reset vector and the fetch-to-decode entry type for the ARM pipeline.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head is readable combinationally so a
// write at one edge is visible at the output in the following cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count_reg == FULL_CNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = entries[rd_ptr_reg];

    // Storage is not reset: an entry is only observable once count covers it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                data_reg <= push_data;
            end
        end

        assign entries[gi] = data_reg;
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (do_pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues credit-limited in-order
// memory requests, queues responses for decode and squashes on redirect.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = cpu_pkg::ADDR_W,
    parameter int          INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [63:0] RESET_PC = 64'(cpu_pkg::RESET_PC),
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
);

    localparam int             CNT_W = $clog2(DEPTH + 1);
    localparam int             Q_W   = INSTR_W + ADDR_W;
    localparam logic [CNT_W:0] CAP   = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]  drop_reg, drop_next;

    logic              req_fire;
    logic              resp_take;
    logic              resp_keep;
    logic              dec_fire;
    logic              credit_ok;

    logic [ADDR_W-1:0] tag_head;
    logic              tag_full, tag_empty;
    logic [CNT_W-1:0]  tag_count;

    logic [Q_W-1:0]    q_push_data;
    logic [Q_W-1:0]    q_head;
    logic              q_full, q_empty;
    logic [CNT_W-1:0]  q_count;

    logic              unused_fifo_status;

    // Credits cover both queued entries and requests still in flight.
    assign credit_ok      = ({1'b0, outstanding_reg} + {1'b0, q_count}) < CAP;
    assign imem_req_valid = reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_take = imem_resp_valid && (outstanding_reg != '0);
    assign resp_keep = resp_take && (drop_reg == '0) && !redirect_valid;

    assign dec_valid = !q_empty;
    assign dec_fire  = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? q_head[ADDR_W +: INSTR_W] : '0;
    assign dec_pc    = dec_valid ? q_head[ADDR_W-1:0] : '0;

    assign q_push_data = {imem_resp_data, tag_head};

    assign unused_fifo_status = &{1'b0, tag_full, tag_empty, tag_count, q_full};

    // Every counted response retires its tag, kept or dropped, to stay aligned.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_reg),
        .pop       (resp_take),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data (q_push_data),
        .pop       (dec_fire),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;

        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (req_fire) begin
            pc_next = pc_reg + ADDR_W'(PC_STEP);
        end

        if (req_fire && !resp_take) begin
            outstanding_next = outstanding_reg + CNT_W'(1);
        end else if (!req_fire && resp_take) begin
            outstanding_next = outstanding_reg - CNT_W'(1);
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            drop_next = outstanding_next;
        end else if (resp_take && (drop_reg != '0)) begin
            drop_next = drop_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= ADDR_W'(RESET_PC);
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

endmodule
